vrf_accesser: RTL

- Initiator side of the banked VRF SRAM array. Arbitrates NrReadPorts operand-read requesters and one write-back requester onto the NrBank single-port banks.
- Issues bank requests and captures the bank read data one cycle later.
- Returns the data to each read port through a 2-entry response FIFO with valid/ready handshake.
- Sits between the lane operand queues / write-back path and the vrf bank array.

---
 rtl/vrf_accesser_pkg.sv | 37 +++
 rtl/vrf_accesser_if.sv | 36 +++
 rtl/vrf_accesser_resp_fifo.sv | 44 ++++
 rtl/vrf_accesser.sv | 92 +++++++++
 4 files changed

// File: rtl/vrf_accesser_pkg.sv
// Shared types and sizing for the VRF accesser: bank/word address split and
// the round-robin index helper used by the per-bank arbiters.
package vrf_accesser_pkg;

  localparam int unsigned NrBank                  = 4;
  localparam int unsigned NrReadPorts             = 3;
  localparam int unsigned VRFSlicePerBankNumWords = 64;
  localparam int unsigned VRFWordWidth            = 64;

  localparam int unsigned BankSelWidth  = $clog2(NrBank);
  localparam int unsigned BankAddrWidth = $clog2(VRFSlicePerBankNumWords);
  localparam int unsigned PortIdxWidth  = (NrReadPorts > 1) ? $clog2(NrReadPorts) : 1;

  typedef logic [BankAddrWidth-1:0]              bank_addr_t;
  typedef logic [BankAddrWidth+BankSelWidth-1:0] vrf_addr_t;
  typedef logic [VRFWordWidth-1:0]               vrf_data_t;
  typedef logic [VRFWordWidth/8-1:0]             vrf_strb_t;
  typedef logic [BankSelWidth-1:0]               bank_sel_t;
  typedef logic [PortIdxWidth-1:0]               port_idx_t;

  function automatic bank_sel_t addr_bank(vrf_addr_t a);
    return a[BankSelWidth-1:0];
  endfunction

  function automatic bank_addr_t addr_word(vrf_addr_t a);
    return a[BankSelWidth +: BankAddrWidth];
  endfunction

  // (start + offset) mod NrReadPorts, valid for start, offset < NrReadPorts
  function automatic port_idx_t rr_port(port_idx_t start, int unsigned offset);
    int unsigned idx;
    idx = 32'(start) + offset;
    if (idx >= NrReadPorts) idx = idx - NrReadPorts;
    return port_idx_t'(idx);
  endfunction

endpackage

// File: rtl/vrf_accesser_if.sv
// Requester-side and bank-side signals of the VRF accesser. The accesser
// takes the slave view; the requesters plus bank array take the master view.
interface vrf_accesser_if;
  import vrf_accesser_pkg::*;

  logic [NrReadPorts-1:0]            rd_valid;
  logic [NrReadPorts-1:0]            rd_ready;
  vrf_addr_t [NrReadPorts-1:0]       rd_addr;
  logic [NrReadPorts-1:0]            rd_resp_valid;
  logic [NrReadPorts-1:0]            rd_resp_ready;
  vrf_data_t [NrReadPorts-1:0]       rd_resp_data;

  logic                              wr_valid;
  logic                              wr_ready;
  vrf_addr_t                         wr_addr;
  vrf_data_t                         wr_data;
  vrf_strb_t                         wr_strb;

  logic [NrBank-1:0]                 req;
  bank_addr_t [NrBank-1:0]           addr;
  logic [NrBank-1:0]                 wen;
  vrf_data_t [NrBank-1:0]            wdata;
  vrf_strb_t [NrBank-1:0]            wstrb;
  vrf_data_t [NrBank-1:0]            rdata;

  modport slave (
    input  rd_valid, rd_addr, rd_resp_ready, wr_valid, wr_addr, wr_data, wr_strb, rdata,
    output rd_ready, rd_resp_valid, rd_resp_data, wr_ready, req, addr, wen, wdata, wstrb
  );

  modport master (
    output rd_valid, rd_addr, rd_resp_ready, wr_valid, wr_addr, wr_data, wr_strb, rdata,
    input  rd_ready, rd_resp_valid, rd_resp_data, wr_ready, req, addr, wen, wdata, wstrb
  );

endinterface

// File: rtl/vrf_accesser_resp_fifo.sv
// Two-entry response FIFO with fall-through when empty, so bank data arriving
// in the cycle after the grant is visible to the consumer in that same cycle.
module vrf_accesser_resp_fifo import vrf_accesser_pkg::*; (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      in_valid,
  input  vrf_data_t in_data,
  input  logic      out_ready,
  output logic      out_valid,
  output vrf_data_t out_data,
  output logic [1:0] occupancy
);

  vrf_data_t  mem [2];
  logic       rd_ptr, wr_ptr;
  logic [1:0] count;
  logic       empty, pop, store, take;

  assign empty     = (count == 2'd0);
  assign out_valid = !rst_i && (!empty || in_valid);
  assign out_data  = empty ? in_data : mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  // an incoming word popped straight through never occupies an entry
  assign store     = in_valid && !(empty && pop);
  assign take      = pop && !empty;
  assign occupancy = count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (store) wr_ptr <= ~wr_ptr;
      if (take)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, store} - {1'b0, take};
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/vrf_accesser.sv
// Banked VRF initiator: the write owns its bank, reads share the rest
// round-robin per bank, and bank data returns through per-port response FIFOs.
module vrf_accesser import vrf_accesser_pkg::*; (
  input logic           clk_i,
  input logic           rst_i,
  vrf_accesser_if.slave bus
);

  logic [NrReadPorts-1:0]       inflight_q;
  bank_sel_t [NrReadPorts-1:0]  bank_q;
  port_idx_t [NrBank-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NrReadPorts-1:0]       eligible, grant, pop, resp_valid;
  logic [NrReadPorts-1:0][1:0]  occupancy;
  vrf_data_t [NrReadPorts-1:0]  push_data, resp_data;
  port_idx_t                    cand;
  logic                         found;

  for (genvar p = 0; p < NrReadPorts; p++) begin : g_port
    assign push_data[p] = bus.rdata[bank_q[p]];
    assign pop[p]       = resp_valid[p] & bus.rd_resp_ready[p];
    // credit = 2 - occupancy - inflight + pop, eligible while credit > 0
    assign eligible[p]  = ({1'b0, occupancy[p]} + {2'b00, inflight_q[p]}) < (3'd2 + {2'b00, pop[p]});

    vrf_accesser_resp_fifo i_resp_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .in_valid  (inflight_q[p]),
      .in_data   (push_data[p]),
      .out_ready (bus.rd_resp_ready[p]),
      .out_valid (resp_valid[p]),
      .out_data  (resp_data[p]),
      .occupancy (occupancy[p])
    );
  end

  assign bus.rd_resp_valid = resp_valid;
  assign bus.rd_resp_data  = resp_data;
  assign bus.rd_ready      = grant;

  always_comb begin
    bus.req      = '0;
    bus.wen      = '0;
    bus.addr     = '0;
    bus.wdata    = '0;
    bus.wstrb    = '0;
    bus.wr_ready = 1'b0;
    grant        = '0;
    rr_ptr_d     = rr_ptr_q;
    cand         = '0;
    found        = 1'b0;
    if (!rst_i) begin
      for (int b = 0; b < NrBank; b++) begin
        if (bus.wr_valid && addr_bank(bus.wr_addr) == bank_sel_t'(b)) begin
          bus.wr_ready = 1'b1;
          bus.req[b]   = 1'b1;
          bus.wen[b]   = 1'b1;
          bus.addr[b]  = addr_word(bus.wr_addr);
          bus.wdata[b] = bus.wr_data;
          bus.wstrb[b] = bus.wr_strb;
        end else begin
          found = 1'b0;
          for (int k = 0; k < NrReadPorts; k++) begin
            cand = rr_port(rr_ptr_q[b], k);
            if (!found && bus.rd_valid[cand] && eligible[cand] &&
                addr_bank(bus.rd_addr[cand]) == bank_sel_t'(b)) begin
              found       = 1'b1;
              grant[cand] = 1'b1;
              bus.req[b]  = 1'b1;
              bus.addr[b] = addr_word(bus.rd_addr[cand]);
              rr_ptr_d[b] = rr_port(cand, 1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= '0;
      bank_q     <= '0;
      rr_ptr_q   <= '0;
    end else begin
      inflight_q <= grant;
      rr_ptr_q   <= rr_ptr_d;
      for (int p = 0; p < NrReadPorts; p++) begin
        if (grant[p]) bank_q[p] <= addr_bank(bus.rd_addr[p]);
      end
    end
  end

endmodule
